// File: rtl/piezo_melody_ctrl.sv
// piezo_melody_ctrl: arbitrates the piezo key-select between the manual key
// switches (while idle) and a 16-entry melody ROM (while playing). Handles
// beat timing, inter-note gaps, rests, looped playback and abort.
module piezo_melody_ctrl #(
    parameter int BEAT_DIV = 2500000,
    parameter int GAP_CYC  = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] sw_key,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    output logic [11:0] key_out,
    output logic        busy,
    output logic        done,
    output logic [3:0]  note_idx
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [23:0] BEAT_LAST = 24'(BEAT_DIV - 1);
    localparam logic [23:0] GAP_LAST  = 24'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic        HAS_GAP   = (GAP_CYC > 0);

    // Melody ROM: {code[3:0], dur[1:0]}; code 0 = rest, 1..12 = key, 13..15 = END.
    function automatic logic [5:0] rom_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    rom_entry = {4'd1,  2'd0};
            4'd1:    rom_entry = {4'd3,  2'd0};
            4'd2:    rom_entry = {4'd5,  2'd0};
            4'd3:    rom_entry = {4'd6,  2'd0};
            4'd4:    rom_entry = {4'd8,  2'd0};
            4'd5:    rom_entry = {4'd10, 2'd0};
            4'd6:    rom_entry = {4'd12, 2'd0};
            4'd7:    rom_entry = {4'd8,  2'd2};
            4'd8:    rom_entry = {4'd0,  2'd1};
            default: rom_entry = {4'd15, 2'd0};
        endcase
    endfunction

    function automatic logic [11:0] key_onehot(input logic [3:0] code);
        if (code >= 4'd1 && code <= 4'd12)
            key_onehot = 12'd1 << (code - 4'd1);
        else
            key_onehot = 12'd0;
    endfunction

    function automatic logic is_end(input logic [3:0] code);
        is_end = (code >= 4'd13);
    endfunction

    // Index of the final beat for a duration code (1/2/4/8 beats).
    function automatic logic [2:0] last_beat(input logic [1:0] dur);
        case (dur)
            2'd0:    last_beat = 3'd0;
            2'd1:    last_beat = 3'd1;
            2'd2:    last_beat = 3'd3;
            default: last_beat = 3'd7;
        endcase
    endfunction

    function automatic logic one_bit_set(input logic [11:0] v);
        one_bit_set = (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
    endfunction

    logic [1:0]  state;
    logic [23:0] prescale;
    logic [2:0]  beat_cnt;
    logic [23:0] gap_cnt;

    logic [5:0]  cur_entry;
    logic [3:0]  cur_code;
    logic        note_end;
    logic [3:0]  next_idx;
    logic [5:0]  next_entry;

    logic [1:0]  fetch_state;
    logic [3:0]  fetch_idx;
    logic [11:0] fetch_key;
    logic        fetch_busy;
    logic        fetch_done;

    // Decode the current entry and detect the last cycle of its last beat.
    always_comb begin
        cur_entry  = rom_entry(note_idx);
        cur_code   = cur_entry[5:2];
        note_end   = (prescale == BEAT_LAST) && (beat_cnt == last_beat(cur_entry[1:0]));
        next_idx   = note_idx + 4'd1;
        next_entry = rom_entry(next_idx);
    end

    // Outcome of advancing to the next entry: finish, wrap to entry 0, or play it.
    always_comb begin
        fetch_state = S_PLAY;
        fetch_idx   = next_idx;
        fetch_key   = key_onehot(next_entry[5:2]);
        fetch_busy  = 1'b1;
        fetch_done  = 1'b0;
        if (is_end(next_entry[5:2])) begin
            if (loop) begin
                fetch_idx = 4'd0;
                fetch_key = key_onehot(rom_entry(4'd0) >> 2);
            end else begin
                fetch_state = S_IDLE;
                fetch_key   = 12'd0;
                fetch_busy  = 1'b0;
                fetch_done  = 1'b1;
            end
        end
    end

    // Sequencer state machine; every output is registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            key_out  <= 12'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            note_idx <= 4'd0;
            prescale <= 24'd0;
            beat_cnt <= 3'd0;
            gap_cnt  <= 24'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state    <= S_PLAY;
                        note_idx <= 4'd0;
                        key_out  <= key_onehot(rom_entry(4'd0) >> 2);
                        busy     <= 1'b1;
                        prescale <= 24'd0;
                        beat_cnt <= 3'd0;
                        gap_cnt  <= 24'd0;
                    end else begin
                        key_out <= one_bit_set(sw_key) ? sw_key : 12'd0;
                    end
                end
                S_PLAY: begin
                    if (stop) begin
                        state   <= S_IDLE;
                        key_out <= 12'd0;
                        busy    <= 1'b0;
                    end else if (note_end) begin
                        if (HAS_GAP && key_onehot(cur_code) != 12'd0) begin
                            state   <= S_GAP;
                            key_out <= 12'd0;
                            gap_cnt <= 24'd0;
                        end else begin
                            state    <= fetch_state;
                            note_idx <= fetch_idx;
                            key_out  <= fetch_key;
                            busy     <= fetch_busy;
                            done     <= fetch_done;
                            prescale <= 24'd0;
                            beat_cnt <= 3'd0;
                        end
                    end else if (prescale == BEAT_LAST) begin
                        prescale <= 24'd0;
                        beat_cnt <= beat_cnt + 3'd1;
                    end else begin
                        prescale <= prescale + 24'd1;
                    end
                end
                S_GAP: begin
                    if (stop) begin
                        state   <= S_IDLE;
                        key_out <= 12'd0;
                        busy    <= 1'b0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state    <= fetch_state;
                        note_idx <= fetch_idx;
                        key_out  <= fetch_key;
                        busy     <= fetch_busy;
                        done     <= fetch_done;
                        prescale <= 24'd0;
                        beat_cnt <= 3'd0;
                        gap_cnt  <= 24'd0;
                    end else begin
                        gap_cnt <= gap_cnt + 24'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    key_out <= 12'd0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piezo_melody_ctrl.sv
// Bench for piezo_melody_ctrl: directed song/loop/abort/reset scenarios and a
// randomized phase, all compared against a timeline model of the melody.
module tb_piezo_melody_ctrl;

    localparam int BEAT_DIV = 4;
    localparam int GAP_CYC  = 2;
    localparam int END_IDX  = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] sw_key = 12'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [11:0] key_out;
    logic        busy;
    logic        done;
    logic [3:0]  note_idx;

    piezo_melody_ctrl #(.BEAT_DIV(BEAT_DIV), .GAP_CYC(GAP_CYC)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_key   (sw_key),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .key_out  (key_out),
        .busy     (busy),
        .done     (done),
        .note_idx (note_idx)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Song as written in the melody table: key code (0 = rest) and beats.
    int song_code  [0:8] = '{1, 3, 5, 6, 8, 10, 12, 8, 0};
    int song_beats [0:8] = '{1, 1, 1, 1, 1, 1, 1, 4, 2};

    // Remaining per-cycle output timeline of the song being played.
    int q_key [$];
    int q_idx [$];

    logic [11:0] m_key  = 12'd0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [3:0]  m_idx  = 4'd0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void load_song();
        q_key.delete();
        q_idx.delete();
        for (int i = 0; i < 9; i++) begin
            for (int n = 0; n < song_beats[i] * BEAT_DIV; n++) begin
                q_key.push_back(song_code[i] == 0 ? 0 : (1 << (song_code[i] - 1)));
                q_idx.push_back(i);
            end
            if (song_code[i] != 0) begin
                for (int n = 0; n < GAP_CYC; n++) begin
                    q_key.push_back(0);
                    q_idx.push_back(i);
                end
            end
        end
    endfunction

    function automatic void model_reset();
        m_key  = 12'd0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_idx  = 4'd0;
        q_key.delete();
        q_idx.delete();
    endfunction

    function automatic void pop_timeline();
        m_key = 12'(q_key.pop_front());
        m_idx = 4'(q_idx.pop_front());
    endfunction

    // Reference behaviour for one clock edge, using the inputs held at that edge.
    function automatic void model_edge();
        if (!reset) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (m_busy) begin
            if (stop) begin
                m_busy = 1'b0;
                m_key  = 12'd0;
                q_key.delete();
                q_idx.delete();
            end else if (q_key.size() > 0) begin
                pop_timeline();
            end else if (loop) begin
                load_song();
                pop_timeline();
            end else begin
                m_busy = 1'b0;
                m_key  = 12'd0;
                m_done = 1'b1;
                m_idx  = 4'(END_IDX);
            end
        end else begin
            if (start && !stop) begin
                load_song();
                pop_timeline();
                m_busy = 1'b1;
            end else begin
                m_key = ($countones(sw_key) == 1) ? sw_key : 12'd0;
            end
        end
    endfunction

    task automatic compare_outputs();
        check_val("key_out",  32'(key_out),  32'(m_key));
        check_val("busy",     32'(busy),     32'(m_busy));
        check_val("done",     32'(done),     32'(m_done));
        check_val("note_idx", 32'(note_idx), 32'(m_idx));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    // Drop reset between edges, check the immediate clear, hold, then release.
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_val("rst_key",  32'(key_out),  32'h0);
        check_val("rst_busy", 32'(busy),     32'h0);
        check_val("rst_idx",  32'(note_idx), 32'h0);
        check_val("rst_done", 32'(done),     32'h0);
        step();
        step();
        @(negedge clk);
        reset = 1'b1;
        step();
        check_val("post_rst_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        // Power-up reset
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        step();
        @(negedge clk);
        reset = 1'b1;
        step();

        // Idle passthrough
        sw_key = 12'h010;
        step();
        check_val("idle_one_hot", 32'(key_out), 32'h010);
        sw_key = 12'h011;
        step();
        check_val("idle_two_bits", 32'(key_out), 32'h000);
        sw_key = 12'h000;
        step();
        check_val("idle_zero", 32'(key_out), 32'h000);

        // Full song, with a start pulse at cycle 10 that must be ignored
        loop  = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 72; c++) begin
            step();
            start = 1'b0;
            if (c == 10) start = 1'b1;
            case (c)
                1:  begin
                        check_val("song_c1_key", 32'(key_out), 32'h001);
                        check_val("song_c1_busy", 32'(busy), 32'h1);
                        check_val("song_c1_idx", 32'(note_idx), 32'h0);
                    end
                4:  check_val("song_c4_key", 32'(key_out), 32'h001);
                5:  check_val("song_c5_gap", 32'(key_out), 32'h000);
                6:  check_val("song_c6_gap", 32'(key_out), 32'h000);
                7:  check_val("song_c7_key", 32'(key_out), 32'h004);
                10: check_val("song_c10_key", 32'(key_out), 32'h004);
                13: check_val("song_c13_key", 32'(key_out), 32'h010);
                43: check_val("song_c43_key", 32'(key_out), 32'h080);
                58: check_val("song_c58_key", 32'(key_out), 32'h080);
                59: check_val("song_c59_gap", 32'(key_out), 32'h000);
                61: begin
                        check_val("song_c61_rest", 32'(key_out), 32'h000);
                        check_val("song_c61_busy", 32'(busy), 32'h1);
                    end
                68: check_val("song_c68_rest", 32'(key_out), 32'h000);
                69: begin
                        check_val("song_c69_done", 32'(done), 32'h1);
                        check_val("song_c69_busy", 32'(busy), 32'h0);
                        check_val("song_c69_idx", 32'(note_idx), 32'(END_IDX));
                    end
                70: check_val("song_c70_done", 32'(done), 32'h0);
                default: ;
            endcase
        end

        // Looped playback
        loop  = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 75; c++) begin
            step();
            start = 1'b0;
            if (c == 69) begin
                check_val("loop_c69_key", 32'(key_out), 32'h001);
                check_val("loop_c69_idx", 32'(note_idx), 32'h0);
                check_val("loop_c69_busy", 32'(busy), 32'h1);
                check_val("loop_c69_done", 32'(done), 32'h0);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        loop = 1'b0;
        check_val("loop_stop_busy", 32'(busy), 32'h0);

        // Abort at cycle 20, restart at cycle 25
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            start = 1'b0;
            stop  = 1'b0;
            if (c == 20) stop = 1'b1;
            if (c == 25) start = 1'b1;
            if (c == 21) begin
                check_val("abort_key", 32'(key_out), 32'h000);
                check_val("abort_busy", 32'(busy), 32'h0);
                check_val("abort_done", 32'(done), 32'h0);
            end
            if (c == 26) begin
                check_val("restart_key", 32'(key_out), 32'h001);
                check_val("restart_idx", 32'(note_idx), 32'h0);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;

        // start and stop together in idle
        start = 1'b1;
        stop  = 1'b1;
        step();
        check_val("collide_busy", 32'(busy), 32'h0);
        start = 1'b0;
        stop  = 1'b0;
        step();
        check_val("collide_still_idle", 32'(busy), 32'h0);

        // Reset in the middle of playback
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            start = 1'b0;
        end
        async_reset();

        // Randomized phase
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 1) == 0)
                sw_key = 12'd1 << $urandom_range(0, 11);
            else
                sw_key = 12'($urandom());
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 149) == 0);
            loop  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 599) == 0)
                async_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
